// File: rtl/nird_riu2_seq_ctrl.sv
// Frame sequencer for the NIRD riu2 mapping pipeline: issues 3x3 windows, gates on credits, reports frame end.
// Optional stall counter output is compiled in when NIRD_RIU2_PERF_CNT_EN is defined.
module nird_riu2_seq_ctrl #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int CNT_W   = 10,
   parameter int CREDITS = 4,
   parameter int MAP_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             win_valid_i,
   output logic             win_ready_o,
   output logic             map_en_o,
   output logic             map_last_o,
   input  logic             map_done_i,
   input  logic             map_last_i,
   input  logic             credit_ret_i,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic [CNT_W-1:0] row_o,
   output logic [CNT_W-1:0] col_o,
   output logic             err_o
`ifdef NIRD_RIU2_PERF_CNT_EN
   ,output logic [31:0]     stall_cnt_o
`endif
);

   // state   | meaning
   // S_IDLE  | waiting for start_i
   // S_RUN   | issuing windows while credits remain
   // S_DRAIN | final window issued, waiting for the mapper's last result
   // S_DONE  | one-cycle frame completion

   localparam int COLS  = IMG_W - 2;
   localparam int ROWS  = IMG_H - 2;
   localparam int CR_W  = 4;
   localparam int OUT_W = $clog2(MAP_LAT + 2);

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
   localparam logic [CR_W-1:0]  CR_FULL  = CR_W'(CREDITS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_nxt;
   logic [CR_W-1:0]   cred_q;
   logic [OUT_W-1:0]  out_q;
   logic [CNT_W-1:0]  row_q, col_q;
   logic              busy_q, done_q, err_q;
   logic              start_acc, issue, at_last, err_set;

   assign start_acc   = (state_q == S_IDLE) && start_i;
   assign at_last     = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign win_ready_o = (state_q == S_RUN) && (cred_q != '0);
   assign issue       = win_valid_i && win_ready_o;
   assign map_en_o    = issue;
   assign map_last_o  = issue && at_last;

   // A return alongside an issue is a legal swap, so only a lone return at full credit is an error.
   assign err_set = (credit_ret_i && !issue && (cred_q == CR_FULL)) ||
                    (map_done_i && (out_q == '0)) ||
                    (map_last_i && (state_q == S_RUN));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_nxt = S_RUN;
         S_RUN:   if (map_last_o) state_nxt = S_DRAIN;
         S_DRAIN: if (map_done_i && map_last_i && (out_q == OUT_W'(1))) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         row_q  <= '0;
         col_q  <= '0;
         cred_q <= CR_FULL;
         out_q  <= '0;
      end else begin
         busy_q <= (state_nxt != S_IDLE);
         done_q <= (state_nxt == S_DONE);
         if (start_acc) begin
            err_q  <= 1'b0;
            row_q  <= '0;
            col_q  <= '0;
            cred_q <= CR_FULL;
            out_q  <= '0;
         end else begin
            if (err_set) err_q <= 1'b1;
            // Row/col freeze on the final window so they read back as the frame's last position.
            if (issue && !at_last) begin
               if (col_q == COL_LAST) begin
                  col_q <= '0;
                  row_q <= row_q + CNT_W'(1);
               end else begin
                  col_q <= col_q + CNT_W'(1);
               end
            end
            case ({issue, credit_ret_i})
               2'b10:   cred_q <= cred_q - CR_W'(1);
               2'b01:   if (cred_q != CR_FULL) cred_q <= cred_q + CR_W'(1);
               default: cred_q <= cred_q;
            endcase
            case ({issue, map_done_i})
               2'b10:   out_q <= out_q + OUT_W'(1);
               2'b01:   if (out_q != '0) out_q <= out_q - OUT_W'(1);
               default: out_q <= out_q;
            endcase
         end
      end
   end

   assign busy_o       = busy_q;
   assign frame_done_o = done_q;
   assign err_o        = err_q;
   assign row_o        = row_q;
   assign col_o        = col_q;

`ifdef NIRD_RIU2_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         stall_q <= '0;
      end else if ((state_q == S_RUN) && win_valid_i && (cred_q == '0) && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   // Stall counter not built.
`endif

endmodule

// File: tb/tb_nird_riu2_seq_ctrl.sv
// Self-checking bench for nird_riu2_seq_ctrl on a 6x5 image (4x3 interior windows), 4 credits, mapper latency 3.
module tb_nird_riu2_seq_ctrl;

   localparam int IMG_W   = 6;
   localparam int IMG_H   = 5;
   localparam int CNT_W   = 10;
   localparam int CREDITS = 4;
   localparam int MAP_LAT = 3;
   localparam int COLS    = IMG_W - 2;
   localparam int ROWS    = IMG_H - 2;
   localparam int NWIN    = COLS * ROWS;

   logic             clk, rst, start_i, win_valid_i, win_ready_o, map_en_o, map_last_o;
   logic             map_done_i, map_last_i, credit_ret_i, busy_o, frame_done_o, err_o;
   logic [CNT_W-1:0] row_o, col_o;
`ifdef NIRD_RIU2_PERF_CNT_EN
   logic [31:0]      stall_cnt;
`endif

   logic cr_loop, cr_man, inj_done, inj_last;
   logic [MAP_LAT-1:0] pipe_en, pipe_last;
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   nird_riu2_seq_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W), .CREDITS(CREDITS), .MAP_LAT(MAP_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .win_valid_i(win_valid_i),
      .win_ready_o(win_ready_o), .map_en_o(map_en_o), .map_last_o(map_last_o),
      .map_done_i(map_done_i), .map_last_i(map_last_i), .credit_ret_i(credit_ret_i),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .row_o(row_o), .col_o(col_o),
      .err_o(err_o)
`ifdef NIRD_RIU2_PERF_CNT_EN
      ,.stall_cnt_o(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mapper stand-in: fixed-latency delay line that shares rst with the controller.
   always @(posedge clk) begin
      if (rst) begin
         pipe_en   <= '0;
         pipe_last <= '0;
      end else begin
         pipe_en   <= {pipe_en[MAP_LAT-2:0], map_en_o};
         pipe_last <= {pipe_last[MAP_LAT-2:0], map_last_o};
      end
   end

   assign map_done_i   = pipe_en[MAP_LAT-1] | inj_done;
   assign map_last_i   = (pipe_en[MAP_LAT-1] & pipe_last[MAP_LAT-1]) | inj_last;
   assign credit_ret_i = cr_loop ? map_done_i : cr_man;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clk_adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      clk_adv();
      rst = 1'b0;
   endtask

   task automatic count_issues(input int ncyc, output int n);
      n = 0;
      for (int t = 0; t < ncyc; t++) begin
         #1;
         if (map_en_o) n++;
         clk_adv();
      end
   endtask

   // One frame against a window-index model: position = k / COLS, k % COLS; credits = CREDITS - issued + returned;
   // frame end is MAP_LAT+1 cycles after the final issue.
   task automatic run_frame(input int vprob, input bit loop_cr, input bit start_mid,
                            output int n_iss, output int n_last, output int first_iss,
                            output int last_iss, output int done_at);
      int  k, cred, done_exp, r_e, c_e;
      bit  running, in_frame, rdy_e, en_e;
      cr_loop = loop_cr;
      cr_man = 1'b0;
      win_valid_i = 1'b0;
      start_i = 1'b1;
      clk_adv();
      start_i = 1'b0;
      k = 0; cred = CREDITS; running = 1'b1; in_frame = 1'b1; done_exp = -1;
      n_iss = 0; n_last = 0; first_iss = -1; last_iss = -1; done_at = -1;
      for (int t = 0; t < 600 && in_frame; t++) begin
         win_valid_i = ($urandom_range(0, 99) < vprob);
         start_i = start_mid && (k == 2);
         if (!loop_cr) cr_man = (cred < CREDITS) && ($urandom_range(0, 1) == 1);
         #1;
         rdy_e = running && (cred > 0);
         en_e  = rdy_e && win_valid_i;
         r_e = (k < NWIN) ? k / COLS : ROWS - 1;
         c_e = (k < NWIN) ? k % COLS : COLS - 1;
         chk("win_ready", int'(win_ready_o), int'(rdy_e));
         chk("map_en", int'(map_en_o), int'(en_e));
         chk("map_last", int'(map_last_o), int'(en_e && (k == NWIN - 1)));
         chk("row", int'(row_o), r_e);
         chk("col", int'(col_o), c_e);
         chk("busy", int'(busy_o), 1);
         chk("frame_done", int'(frame_done_o), int'(cyc == done_exp));
         chk("err", int'(err_o), 0);
         if (map_en_o) begin
            n_iss++;
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
         end
         if (map_last_o) n_last++;
         if (frame_done_o && done_at < 0) done_at = cyc;
         if (cyc == done_exp) in_frame = 1'b0;
         if (en_e) begin
            k++;
            cred--;
            if (k == NWIN) begin
               running = 1'b0;
               done_exp = cyc + MAP_LAT + 1;
            end
         end
         if (credit_ret_i) cred++;
         clk_adv();
      end
      start_i = 1'b0;
      win_valid_i = 1'b0;
      cr_man = 1'b0;
      chk("frame_timeout", int'(in_frame), 0);
      #1;
      chk("busy_after_frame", int'(busy_o), 0);
      chk("done_after_frame", int'(frame_done_o), 0);
   endtask

   typedef struct {
      bit rst, start, valid, ret, dn, lst;
      bit e_err, e_busy, e_rdy;
   } vec_t;

   vec_t vt[13];

   initial begin
      int n, n_iss, n_last, f_iss, l_iss, d_at, fd_cnt;
      bit seen;

      rst = 1'b1; start_i = 1'b0; win_valid_i = 1'b0;
      cr_loop = 1'b0; cr_man = 1'b0; inj_done = 1'b0; inj_last = 1'b0;

      //          rst st val ret dn lst err busy rdy
      vt[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0};
      vt[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vt[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1};
      vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1};
      vt[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1};
      vt[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vt[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vt[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vt[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1};
      vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1};
      vt[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};

      clk_adv();
      clk_adv();
      rst = 1'b0;
      #1;
      chk("rst_ready", int'(win_ready_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(frame_done_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_row", int'(row_o), 0);
      chk("rst_col", int'(col_o), 0);

      for (int i = 0; i < 13; i++) begin
         rst = vt[i].rst; start_i = vt[i].start; win_valid_i = vt[i].valid;
         cr_man = vt[i].ret; inj_done = vt[i].dn; inj_last = vt[i].lst;
         clk_adv();
         rst = 1'b0; start_i = 1'b0; win_valid_i = 1'b0;
         cr_man = 1'b0; inj_done = 1'b0; inj_last = 1'b0;
         #1;
         chk($sformatf("vec%0d_err", i), int'(err_o), int'(vt[i].e_err));
         chk($sformatf("vec%0d_busy", i), int'(busy_o), int'(vt[i].e_busy));
         chk($sformatf("vec%0d_ready", i), int'(win_ready_o), int'(vt[i].e_rdy));
      end

      // Full-rate frame with credits returned by mapper results.
      run_frame(100, 1'b1, 1'b0, n_iss, n_last, f_iss, l_iss, d_at);
      chk("a_issues", n_iss, 12);
      chk("a_last_count", n_last, 1);
      chk("a_consecutive", l_iss - f_iss, 11);
      chk("a_done_delay", d_at - l_iss, 4);

      // Credit starvation, single-credit top-up, and return coincident with issue at one credit.
      cr_loop = 1'b0; cr_man = 1'b0;
      start_i = 1'b1;
      clk_adv();
      start_i = 1'b0;
      win_valid_i = 1'b1;
      count_issues(10, n);
      chk("starve_issues", n, 4);
      chk("starve_ready", int'(win_ready_o), 0);
      cr_man = 1'b1;
      clk_adv();
      cr_man = 1'b0;
      count_issues(6, n);
      chk("one_credit_issues", n, 1);
      chk("one_credit_ready", int'(win_ready_o), 0);
      cr_man = 1'b1;
      clk_adv();
      cr_man = 1'b0;
      #1;
      chk("cr1_ready", int'(win_ready_o), 1);
      chk("cr1_issue", int'(map_en_o), 1);
      cr_man = 1'b1;
      clk_adv();
      cr_man = 1'b0;
      #1;
      chk("swap_ready", int'(win_ready_o), 1);
      clk_adv();
      #1;
      chk("swap_drained_ready", int'(win_ready_o), 0);
      chk("swap_row", int'(row_o), 1);
      chk("swap_col", int'(col_o), 3);
      chk("swap_err", int'(err_o), 0);
      win_valid_i = 1'b0;
      pulse_rst();

      // start_i while running is ignored.
      run_frame(100, 1'b1, 1'b1, n_iss, n_last, f_iss, l_iss, d_at);
      chk("c_issues", n_iss, 12);
      chk("c_last_count", n_last, 1);

      // Reset while draining.
      cr_loop = 1'b1;
      start_i = 1'b1;
      clk_adv();
      start_i = 1'b0;
      win_valid_i = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
         #1;
         if (map_last_o) seen = 1'b1;
         clk_adv();
      end
      win_valid_i = 1'b0;
      chk("drain_reached", int'(seen), 1);
      #1;
      chk("drain_busy", int'(busy_o), 1);
      chk("drain_ready", int'(win_ready_o), 0);
      pulse_rst();
      #1;
      chk("drst_busy", int'(busy_o), 0);
      chk("drst_ready", int'(win_ready_o), 0);
      chk("drst_row", int'(row_o), 0);
      chk("drst_col", int'(col_o), 0);
      fd_cnt = 0;
      for (int t = 0; t < 8; t++) begin
         #1;
         if (frame_done_o) fd_cnt++;
         clk_adv();
      end
      chk("drst_no_frame_done", fd_cnt, 0);
      chk("drst_err", int'(err_o), 0);
      cr_loop = 1'b0;
      start_i = 1'b1;
      clk_adv();
      start_i = 1'b0;
      win_valid_i = 1'b1;
      count_issues(10, n);
      chk("drst_credits", n, 4);
      win_valid_i = 1'b0;
      pulse_rst();
      run_frame(100, 1'b1, 1'b0, n_iss, n_last, f_iss, l_iss, d_at);
      chk("e_issues", n_iss, 12);

      // Randomized frames: random valid density, alternating credit sources.
      for (int i = 0; i < 6; i++) begin
         run_frame($urandom_range(25, 100), (i % 2) == 0, 1'b0, n_iss, n_last, f_iss, l_iss, d_at);
         chk("rand_issues", n_iss, 12);
         chk("rand_done_delay", d_at - l_iss, MAP_LAT + 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
